// File: rtl/hazard_match_unit.sv
// hazard_match_unit: carries register numbers and control bits of each
// instruction through the Execute, Memory and Writeback stage registers and
// derives the register-match and PC-write status terms used by the hazard unit.
// Every output is combinational on the stage registers and the Decode inputs,
// so the hazard unit sees them in the same cycle it acts on them.
module hazard_match_unit #(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic             FlushE,
  output logic             Match_1E_M,
  output logic             Match_1E_W,
  output logic             Match_2E_M,
  output logic             Match_2E_W,
  output logic             Match_12D_E,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemtoRegE,
  output logic             PCWrPendingF,
  output logic             PCSrcW
);

  // The PC register number is never a forwarding source or target.
  localparam logic [REG_W-1:0] PcAddr = REG_W'(PC_REG);

  // Execute stage state
  logic             eValid;
  logic [REG_W-1:0] eRa1;
  logic [REG_W-1:0] eRa2;
  logic [REG_W-1:0] eWa3;
  logic             eRegWrite;
  logic             eMemtoReg;
  logic             ePcSrc;

  // Memory stage state (source numbers are no longer needed here). The load
  // flag is only consumed while the producer sits in Execute, so it is not
  // carried beyond that stage.
  logic             mValid;
  logic [REG_W-1:0] mWa3;
  logic             mRegWrite;
  logic             mPcSrc;

  // Writeback stage state
  logic             wValid;
  logic [REG_W-1:0] wWa3;
  logic             wRegWrite;
  logic             wPcSrc;

  // Execute register: a flush inserts an all-zero bubble, otherwise capture Decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eValid    <= 1'b0;
      eRa1      <= '0;
      eRa2      <= '0;
      eWa3      <= '0;
      eRegWrite <= 1'b0;
      eMemtoReg <= 1'b0;
      ePcSrc    <= 1'b0;
    end else if (FlushE) begin
      eValid    <= 1'b0;
      eRa1      <= '0;
      eRa2      <= '0;
      eWa3      <= '0;
      eRegWrite <= 1'b0;
      eMemtoReg <= 1'b0;
      ePcSrc    <= 1'b0;
    end else begin
      eValid    <= 1'b1;
      eRa1      <= RA1D;
      eRa2      <= RA2D;
      eWa3      <= WA3D;
      eRegWrite <= RegWriteD;
      eMemtoReg <= MemtoRegD;
      ePcSrc    <= PCSrcD;
    end
  end

  // Memory register: follows Execute every edge; bubbles travel as valid=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mValid    <= 1'b0;
      mWa3      <= '0;
      mRegWrite <= 1'b0;
      mPcSrc    <= 1'b0;
    end else begin
      mValid    <= eValid;
      mWa3      <= eWa3;
      mRegWrite <= eRegWrite;
      mPcSrc    <= ePcSrc;
    end
  end

  // Writeback register: follows Memory every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wValid    <= 1'b0;
      wWa3      <= '0;
      wRegWrite <= 1'b0;
      wPcSrc    <= 1'b0;
    end else begin
      wValid    <= mValid;
      wWa3      <= mWa3;
      wRegWrite <= mRegWrite;
      wPcSrc    <= mPcSrc;
    end
  end

  // Per-source qualifiers: a source equal to the PC never matches anything.
  logic src1ENotPc;
  logic src2ENotPc;
  logic src1DNotPc;
  logic src2DNotPc;
  logic prodM;
  logic prodW;
  logic prodE;

  assign src1ENotPc = (eRa1 != PcAddr);
  assign src2ENotPc = (eRa2 != PcAddr);
  assign src1DNotPc = (RA1D != PcAddr);
  assign src2DNotPc = (RA2D != PcAddr);

  // A stage can only be a forwarding producer when it holds a real register write.
  assign prodM = eValid & mValid & mRegWrite;
  assign prodW = eValid & wValid & wRegWrite;
  assign prodE = eValid & eRegWrite;

  // Execute-stage forwarding matches against Memory and Writeback destinations.
  assign Match_1E_M = prodM & (eRa1 == mWa3) & src1ENotPc;
  assign Match_1E_W = prodW & (eRa1 == wWa3) & src1ENotPc;
  assign Match_2E_M = prodM & (eRa2 == mWa3) & src2ENotPc;
  assign Match_2E_W = prodW & (eRa2 == wWa3) & src2ENotPc;

  // Load-use check: either Decode source depends on the instruction in Execute.
  assign Match_12D_E = prodE & (((RA1D == eWa3) & src1DNotPc) |
                                ((RA2D == eWa3) & src2DNotPc));

  // Stage control bits; invalid stages always hold zeros here.
  assign RegWriteM = mRegWrite;
  assign RegWriteW = wRegWrite;
  assign MemtoRegE = eMemtoReg;

  // A PC write anywhere ahead of Writeback keeps fetch waiting.
  assign PCWrPendingF = PCSrcD | ePcSrc | mPcSrc;
  assign PCSrcW       = wPcSrc;

endmodule

// File: tb/tb_hazard_match_unit.sv
// Directed bench for hazard_match_unit: a table of per-cycle Decode inputs with
// hand-derived output vectors, plus reset sequences around it.
module tb_hazard_match_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemtoRegD, PCSrcD, FlushE;
  logic       Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic       RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW;

  int checks = 0;
  int errors = 0;

  // Output vector bit positions
  localparam logic [9:0] M1EM = 10'b1000000000;
  localparam logic [9:0] M1EW = 10'b0100000000;
  localparam logic [9:0] M2EM = 10'b0010000000;
  localparam logic [9:0] M2EW = 10'b0001000000;
  localparam logic [9:0] M12D = 10'b0000100000;
  localparam logic [9:0] RWM  = 10'b0000010000;
  localparam logic [9:0] RWW  = 10'b0000001000;
  localparam logic [9:0] MTRE = 10'b0000000100;
  localparam logic [9:0] PCP  = 10'b0000000010;
  localparam logic [9:0] PCW  = 10'b0000000001;

  typedef struct {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mtr;
    logic       pcs;
    logic       flush;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[15];

  hazard_match_unit #(.REG_W(4), .PC_REG(15)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
    .FlushE(FlushE),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
            RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] got;
    got = outs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b (m1EM m1EW m2EM m2EW m12DE rwM rwW mtrE pcPend pcW)",
               name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic rw, input logic mtr, input logic pcs, input logic flush);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mtr; PCSrcD = pcs; FlushE = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ra1    ra2    wa3    rw mtr pcs fl  expected
    vecs[0]  = '{4'd0,  4'd0,  4'd3,  1, 0, 0, 0, 10'b0};           // I0 writes r3
    vecs[1]  = '{4'd3,  4'd0,  4'd0,  0, 0, 0, 0, M12D};            // reads r3 while I0 in E
    vecs[2]  = '{4'd0,  4'd0,  4'd0,  0, 0, 0, 0, M1EM | RWM};      // E/M forward on source 1
    vecs[3]  = '{4'd0,  4'd0,  4'd5,  1, 0, 0, 0, RWW};             // I1 left E: no E/W match
    vecs[4]  = '{4'd1,  4'd1,  4'd1,  0, 0, 0, 0, 10'b0};           // unrelated
    vecs[5]  = '{4'd0,  4'd5,  4'd0,  0, 0, 0, 0, RWM};             // reads r5 on source 2
    vecs[6]  = '{4'd0,  4'd0,  4'd0,  0, 0, 0, 0, M2EW | RWW};      // E/W forward on source 2
    vecs[7]  = '{4'd0,  4'd0,  4'd2,  1, 1, 0, 0, 10'b0};           // load to r2
    vecs[8]  = '{4'd0,  4'd2,  4'd0,  0, 0, 0, 1, M12D | MTRE};     // load-use, flush asserted
    vecs[9]  = '{4'd0,  4'd2,  4'd0,  0, 0, 0, 0, RWM};             // bubble in E, load in M
    vecs[10] = '{4'd0,  4'd0,  4'd15, 1, 0, 1, 0, M2EW | RWW | PCP}; // PC write in D
    vecs[11] = '{4'd15, 4'd0,  4'd0,  0, 0, 0, 0, PCP};             // reads PC: no load-use
    vecs[12] = '{4'd0,  4'd0,  4'd0,  0, 0, 0, 0, RWM | PCP};       // PC in M: no E/M match
    vecs[13] = '{4'd0,  4'd0,  4'd0,  0, 0, 0, 0, PCW | RWW};       // PC write in W
    vecs[14] = '{4'd0,  4'd0,  4'd0,  0, 0, 0, 0, 10'b0};

    // Reset held with arbitrary inputs
    reset = 1'b0;
    drive(4'd3, 4'd5, 4'd3, 1, 1, 0, 0);
    step();
    step();
    check("reset_hold", 10'b0);
    PCSrcD = 1'b1;
    #1;
    check("reset_pcsrcd", PCP);

    // Release between edges; PCSrcD still reaches PCWrPendingF combinationally
    reset = 1'b1;
    drive(4'd0, 4'd0, 4'd0, 0, 0, 1, 0);
    #1;
    check("release_pcpend", PCP);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ra1, vecs[i].ra2, vecs[i].wa3, vecs[i].rw, vecs[i].mtr,
            vecs[i].pcs, vecs[i].flush);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
      step();
    end

    // Fill E, M, W with writers of r7, then reset asynchronously mid-cycle
    drive(4'd0, 4'd0, 4'd7, 1, 0, 0, 0);
    step();
    drive(4'd0, 4'd0, 4'd7, 1, 0, 0, 0);
    step();
    drive(4'd7, 4'd7, 4'd7, 1, 0, 0, 0);
    step();
    drive(4'd7, 4'd0, 4'd0, 0, 0, 0, 0);
    #1;
    check("prefill", M1EM | M1EW | M2EM | M2EW | M12D | RWM | RWW);
    #1;
    reset = 1'b0;
    #1;
    check("async_clear", 10'b0);
    PCSrcD = 1'b1;
    #1;
    check("async_pcsrcd", PCP);
    PCSrcD = 1'b0;
    step();
    check("reset_after_edge", 10'b0);
    reset = 1'b1;
    #1;
    check("release_empty", M12D & 10'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
